triangle_streamer: RTL and testbench
====================================

TRIANGLE_STREAMER -- requirements
Module: triangle_streamer

Interface
REQ-001 SHALL have parameter MAX_TRIS, default 64, triangle buffer depth.
REQ-002 SHALL have parameter RP_TIMEOUT, default 15, maximum cycles to wait for rp_data_out after rp_data_in falls.
REQ-003 SHALL have parameter BG_COLOR, default 16'h0000, colour emitted for uncovered or timed-out pixels.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports tri_wr_en  in  1, tri_wr_addr  in  6, tri_wr_data  in  triangle_t  buffer write port.
REQ-007 SHALL have port tri_count  in  7  number of valid triangles (0..64), sampled on start.
REQ-008 SHALL have ports x_min, x_max, y_min, y_max  in  18 each  inclusive pixel region, sampled on start.
REQ-009 SHALL have ports start  in  1, busy  out  1, done  out  1 (one-cycle pulse).
REQ-010 SHALL have ports rp_reset  out  1 (active-high), rp_data_in  out  1, rp_point  out  2x18 ([1]=x, [0]=y), rp_v1/rp_v2/rp_v3  out  2x18 each, rp_d1/rp_d2/rp_d3  out  18 each (Q6.12), rp_color  out  16.
REQ-011 SHALL have ports rp_data_out  in  1, rp_color_out  in  16  rasterizer result.
REQ-012 SHALL have ports pix_valid  out  1, pix_ready  in  1, pix_x  out  18, pix_y  out  18, pix_color  out  16.

Function
REQ-013 SHALL implement states IDLE, CLEAR, STREAM, DRAIN, EMIT, FINISH.
REQ-014 IDLE: start=1 -> latch region and tri_count, set point=(x_min,y_min), go to CLEAR; busy=1 in every state except IDLE.
REQ-015 Empty region (x_min>x_max or y_min>y_max) at start -> go directly to FINISH; no pixels emitted.
REQ-016 CLEAR: rp_reset=1 for exactly one cycle, then STREAM; with tri_count=0, go to EMIT with pix_color=BG_COLOR and skip the rasterizer.
REQ-017 STREAM: rp_data_in=1 for exactly tri_count consecutive cycles; cycle k presents buffer entry k (k=0..tri_count-1) on rp_v*, rp_d*, rp_color; then DRAIN.
REQ-018 rp_point SHALL hold the current pixel, stable from CLEAR through DRAIN; rp_data_in=0 in every state except STREAM.
REQ-019 DRAIN: first cycle with rp_data_out=1 -> capture rp_color_out into pix_color, go to EMIT.
REQ-020 DRAIN timeout: RP_TIMEOUT cycles without rp_data_out -> pix_color=BG_COLOR, go to EMIT.
REQ-021 EMIT: pix_valid=1 with pix_x, pix_y, pix_color held stable until pix_valid&&pix_ready; no output may change while pix_ready=0.
REQ-022 On handshake: advance x; at x==x_max, wrap x to x_min and increment y; at (x_max,y_max) go to FINISH, else go to CLEAR.
REQ-023 FINISH: done=1 for one cycle, busy=0 afterwards, return to IDLE.
REQ-024 start while busy SHALL be ignored; tri_wr_en while busy SHALL be ignored (buffer frozen during a scan).
REQ-025 tri_wr_en in IDLE writes the buffer in one cycle; a write in the same cycle as start is not seen by that scan.
REQ-026 Coordinate increments SHALL be 18-bit unsigned; x_max=y_max=2^18-1 terminates via the equality compare, not via overflow.
REQ-027 tri_count>MAX_TRIS SHALL be clamped to MAX_TRIS.

Reset
REQ-028 reset=0 SHALL force state IDLE immediately; outputs busy, done, pix_valid, rp_data_in =0; rp_reset=1; pix_*, rp_point, rp_v*, rp_d*, rp_color =0.
REQ-029 Reset mid-scan SHALL abandon the scan with no done pulse; buffer contents need not be preserved.

Structure
REQ-030 Package raster_pkg SHALL hold triangle_t (v1,v2,v3 as 2x18; d1,d2,d3 as 18; color 16), the coordinate width (18), and the depth width/format constants.
REQ-031 The triangle buffer SHALL be one sub-module, tri_buffer (MAX_TRIS x triangle_t, one write port, one read port); the FSM and counters live in triangle_streamer.

Verification
REQ-032 Load 4 triangles (v1=(50,40), v2=(40,60), v3=(60,60); depths 31, 27, 28, 30; colours 0-3), region (50,50)-(50,50), paired with the rasterizer -> one pixel (50,50) with colour 1, then done.
REQ-033 Load colour 5 (v3=(40,40), misses) and colour 6 (covers), region 1x1 at (50,50) -> pix_color=6.
REQ-034 Region (10,20)-(12,21), tri_count=1 -> 6 pixels in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); one rp_reset pulse per pixel; rp_data_in high 1 cycle each.
REQ-035 Hold pix_ready=0 for 5 cycles in EMIT -> pix_* stable, no new rasterizer pass starts.
REQ-036 Rasterizer stubbed to never raise rp_data_out -> BG_COLOR emitted 15 cycles after rp_data_in falls; tri_count=0 -> BG_COLOR with no rp_data_in.
REQ-037 Assert reset during STREAM -> rp_data_in=0, busy=0 immediately, no done; a fresh start then completes normally.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and widths for the triangle streamer and its triangle buffer.
package raster_pkg;
  localparam int COORD_W    = 18;
  localparam int DEPTH_W    = 18;
  localparam int DEPTH_FRAC = 12;  // depths are Q6.12
  localparam int COLOR_W    = 16;
  localparam int TRI_ADDR_W = 6;

  typedef logic [1:0][COORD_W-1:0] point_t;  // [1]=x, [0]=y

  typedef struct packed {
    point_t             v1;
    point_t             v2;
    point_t             v3;
    logic [DEPTH_W-1:0] d1;
    logic [DEPTH_W-1:0] d2;
    logic [DEPTH_W-1:0] d3;
    logic [COLOR_W-1:0] color;
  } triangle_t;
endpackage

// File: rtl/tri_buffer.sv
// Triangle store: one synchronous write port, one combinational read port.
module tri_buffer
  import raster_pkg::*;
#(
  parameter int MAX_TRIS = 64
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [TRI_ADDR_W-1:0] wr_addr,
  input  triangle_t             wr_data,
  input  logic [TRI_ADDR_W-1:0] rd_addr,
  output triangle_t             rd_data
);
  triangle_t mem [MAX_TRIS];

  always_ff @(posedge clock) begin
    if (wr_en && (32'(wr_addr) < MAX_TRIS)) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/triangle_streamer.sv
// Scans a pixel region, streaming every buffered triangle to the rasterizer per pixel
// and emitting one colour per pixel on a valid/ready port; stalls while pix_ready is low.
module triangle_streamer
  import raster_pkg::*;
#(
  parameter int          MAX_TRIS   = 64,
  parameter int          RP_TIMEOUT = 15,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tri_wr_en,
  input  logic [5:0]       tri_wr_addr,
  input  triangle_t        tri_wr_data,
  input  logic [6:0]       tri_count,
  input  logic [17:0]      x_min,
  input  logic [17:0]      x_max,
  input  logic [17:0]      y_min,
  input  logic [17:0]      y_max,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rp_reset,
  output logic             rp_data_in,
  output logic [1:0][17:0] rp_point,
  output logic [1:0][17:0] rp_v1,
  output logic [1:0][17:0] rp_v2,
  output logic [1:0][17:0] rp_v3,
  output logic [17:0]      rp_d1,
  output logic [17:0]      rp_d2,
  output logic [17:0]      rp_d3,
  output logic [15:0]      rp_color,
  input  logic             rp_data_out,
  input  logic [15:0]      rp_color_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [17:0]      pix_x,
  output logic [17:0]      pix_y,
  output logic [15:0]      pix_color
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam int         TMO_W   = $clog2(RP_TIMEOUT + 1);
  localparam logic [6:0] MAX_CNT = 7'(MAX_TRIS);

  logic [2:0]         state;
  logic [17:0]        cur_x, cur_y, lx_min, lx_max, ly_max;
  logic [6:0]         cnt;
  logic [5:0]         idx;
  logic [TMO_W-1:0]   tmo;
  logic [15:0]        color_q;
  logic [6:0]         cnt_in;
  logic               stream;
  triangle_t          rd_tri;

  assign cnt_in = (tri_count > MAX_CNT) ? MAX_CNT : tri_count;
  assign stream = (state == S_STREAM);

  // Writes coinciding with start are dropped so the scan sees a frozen buffer.
  tri_buffer #(.MAX_TRIS(MAX_TRIS)) u_buf (
    .clock   (clock),
    .wr_en   (tri_wr_en && (state == S_IDLE) && !start),
    .wr_addr (tri_wr_addr),
    .wr_data (tri_wr_data),
    .rd_addr (idx),
    .rd_data (rd_tri)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cur_x   <= '0;
      cur_y   <= '0;
      lx_min  <= '0;
      lx_max  <= '0;
      ly_max  <= '0;
      cnt     <= '0;
      idx     <= '0;
      tmo     <= '0;
      color_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          lx_min <= x_min;
          lx_max <= x_max;
          ly_max <= y_max;
          cnt    <= cnt_in;
          cur_x  <= x_min;
          cur_y  <= y_min;
          state  <= ((x_min > x_max) || (y_min > y_max)) ? S_FINISH : S_CLEAR;
        end
        S_CLEAR: begin
          idx <= '0;
          if (cnt == 7'd0) begin
            color_q <= BG_COLOR;
            state   <= S_EMIT;
          end else begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if ({1'b0, idx} == cnt - 7'd1) begin
            tmo   <= '0;
            state <= S_DRAIN;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_DRAIN: begin
          if (rp_data_out) begin
            color_q <= rp_color_out;
            state   <= S_EMIT;
          end else if (tmo == TMO_W'(RP_TIMEOUT - 1)) begin
            color_q <= BG_COLOR;
            state   <= S_EMIT;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        S_EMIT: if (pix_ready) begin
          // Termination is by equality so a full-range region never relies on wrap.
          if (cur_x == lx_max) begin
            if (cur_y == ly_max) begin
              state <= S_FINISH;
            end else begin
              cur_x <= lx_min;
              cur_y <= cur_y + 18'd1;
              state <= S_CLEAR;
            end
          end else begin
            cur_x <= cur_x + 18'd1;
            state <= S_CLEAR;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);
  assign rp_reset   = !reset || (state == S_CLEAR);
  assign rp_data_in = stream;
  assign rp_point   = {cur_x, cur_y};
  assign rp_v1      = stream ? rd_tri.v1 : '0;
  assign rp_v2      = stream ? rd_tri.v2 : '0;
  assign rp_v3      = stream ? rd_tri.v3 : '0;
  assign rp_d1      = stream ? rd_tri.d1 : '0;
  assign rp_d2      = stream ? rd_tri.d2 : '0;
  assign rp_d3      = stream ? rd_tri.d3 : '0;
  assign rp_color   = stream ? rd_tri.color : '0;
  assign pix_valid  = (state == S_EMIT);
  assign pix_x      = cur_x;
  assign pix_y      = cur_y;
  assign pix_color  = color_q;
endmodule

// File: tb/tb_triangle_streamer.sv
// Scoreboard bench: directed scans push expected pixels; a monitor pops on each handshake.
module tb_triangle_streamer;
  import raster_pkg::*;

  localparam logic [15:0] BG = 16'h0BAD;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             tri_wr_en = 1'b0;
  logic [5:0]       tri_wr_addr = '0;
  triangle_t        tri_wr_data = '0;
  logic [6:0]       tri_count = '0;
  logic [17:0]      x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic             start = 1'b0;
  logic             busy, done, rp_reset, rp_data_in;
  logic [1:0][17:0] rp_point, rp_v1, rp_v2, rp_v3;
  logic [17:0]      rp_d1, rp_d2, rp_d3;
  logic [15:0]      rp_color;
  logic             rp_data_out;
  logic [15:0]      rp_color_out;
  logic             pix_valid;
  logic             pix_ready = 1'b1;
  logic [17:0]      pix_x, pix_y;
  logic [15:0]      pix_color;

  always #5 clock = ~clock;

  triangle_streamer #(.MAX_TRIS(64), .RP_TIMEOUT(15), .BG_COLOR(BG)) dut (
    .clock(clock), .reset(reset),
    .tri_wr_en(tri_wr_en), .tri_wr_addr(tri_wr_addr), .tri_wr_data(tri_wr_data),
    .tri_count(tri_count),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .start(start), .busy(busy), .done(done),
    .rp_reset(rp_reset), .rp_data_in(rp_data_in), .rp_point(rp_point),
    .rp_v1(rp_v1), .rp_v2(rp_v2), .rp_v3(rp_v3),
    .rp_d1(rp_d1), .rp_d2(rp_d2), .rp_d3(rp_d3), .rp_color(rp_color),
    .rp_data_out(rp_data_out), .rp_color_out(rp_color_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
  );

  typedef struct packed {
    logic [17:0] x;
    logic [17:0] y;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   pix_seen = 0, done_seen = 0, rst_pulses = 0, din_cycles = 0;
  int   rast_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic longint edge_fn(input longint ax, ay, bx, by, px, py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic bit covers(input logic [1:0][17:0] a, b, c, p);
    longint e0, e1, e2;
    e0 = edge_fn(a[1], a[0], b[1], b[0], p[1], p[0]);
    e1 = edge_fn(b[1], b[0], c[1], c[0], p[1], p[0]);
    e2 = edge_fn(c[1], c[0], a[1], a[0], p[1], p[0]);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  function automatic triangle_t make_tri(input int x1, y1, x2, y2, x3, y3, d, c);
    triangle_t t;
    t.v1[1] = 18'(x1); t.v1[0] = 18'(y1);
    t.v2[1] = 18'(x2); t.v2[0] = 18'(y2);
    t.v3[1] = 18'(x3); t.v3[0] = 18'(y3);
    t.d1 = 18'(d); t.d2 = 18'(d); t.d3 = 18'(d);
    t.color = 16'(c);
    return t;
  endfunction

  // Rasterizer partner: nearest covering triangle wins, answer 3 cycles after streaming.
  initial begin
    longint      best_d;
    logic [15:0] best_c;
    int          pend, dly;
    rp_data_out = 1'b0; rp_color_out = '0;
    best_d = 64'h7FFF_FFFF; best_c = '0; pend = 0; dly = 0;
    forever begin
      @(negedge clock);
      rp_data_out = 1'b0;
      if (!reset || rp_reset) begin
        best_d = 64'h7FFF_FFFF; best_c = '0; pend = 0;
      end else if (rp_data_in) begin
        if (covers(rp_v1, rp_v2, rp_v3, rp_point) && (longint'(rp_d1) < best_d)) begin
          best_d = longint'(rp_d1); best_c = rp_color;
        end
        pend = 1; dly = 2;
      end else if (pend == 1) begin
        if (dly == 0) begin
          pend = 0;
          if (rast_mode == 0) begin rp_data_out = 1'b1; rp_color_out = best_c; end
        end else dly--;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (rp_reset) rst_pulses++;
        if (rp_data_in) din_cycles++;
        if (done) done_seen++;
        if (pix_valid && pix_ready) begin
          pix_seen++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pixel: got (%0d,%0d) colour %0h, expected none", pix_x, pix_y, pix_color);
          end else begin
            e = exp_q.pop_front();
            check("pix_x", 32'(pix_x), 32'(e.x));
            check("pix_y", 32'(pix_y), 32'(e.y));
            check("pix_color", 32'(pix_color), 32'(e.c));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input int a, input triangle_t t);
    tri_wr_en = 1'b1; tri_wr_addr = 6'(a); tri_wr_data = t;
    tick();
    tri_wr_en = 1'b0;
  endtask

  task automatic expect_pix(input int x, input int y, input logic [15:0] c);
    exp_t e;
    e.x = 18'(x); e.y = 18'(y); e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic go(input int x0, x1, y0, y1, cnt);
    x_min = 18'(x0); x_max = 18'(x1); y_min = 18'(y0); y_max = 18'(y1);
    tri_count = 7'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles, expected done pulse", name, budget);
    end
    tick();
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_sig_datain(input string name);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rp_data_in) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: rp_data_in never rose, expected it within 100 cycles", name);
    end
  endtask

  initial begin
    int n, snap;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_rp_data_in", 32'(rp_data_in), 0);
    check("rst_rp_reset", 32'(rp_reset), 1);
    check("rst_pix_x", 32'(pix_x), 0);
    check("rst_rp_point", 32'(rp_point), 0);
    @(posedge clock); #1 reset = 1'b1;
    tick();

    // Four coincident triangles, nearest (depth 27) is colour 1.
    wr(0, make_tri(50, 40, 40, 60, 60, 60, 31, 0));
    wr(1, make_tri(50, 40, 40, 60, 60, 60, 27, 1));
    wr(2, make_tri(50, 40, 40, 60, 60, 60, 28, 2));
    wr(3, make_tri(50, 40, 40, 60, 60, 60, 30, 3));
    expect_pix(50, 50, 16'd1);
    go(50, 50, 50, 50, 4);
    wait_done("depth_test", 200);

    // Colour 5 misses the pixel despite being nearer; colour 6 covers it.
    wr(0, make_tri(50, 40, 40, 60, 40, 40, 1, 5));
    wr(1, make_tri(50, 40, 40, 60, 60, 60, 10, 6));
    expect_pix(50, 50, 16'd6);
    go(50, 50, 50, 50, 2);
    wait_done("coverage_test", 200);

    // 3x2 region in raster order.
    wr(0, make_tri(0, 0, 100, 0, 0, 100, 50, 9));
    for (int y = 20; y <= 21; y++)
      for (int x = 10; x <= 12; x++) expect_pix(x, y, 16'd9);
    rst_pulses = 0; din_cycles = 0;
    go(10, 12, 20, 21, 1);
    wait_done("region_scan", 400);
    check("rp_reset_pulses", 32'(rst_pulses), 6);
    check("rp_data_in_cycles", 32'(din_cycles), 6);

    // Back-pressure: everything frozen while pix_ready is low.
    pix_ready = 1'b0;
    expect_pix(7, 7, 16'd9);
    expect_pix(8, 7, 16'd9);
    go(7, 8, 7, 7, 1);
    n = 0;
    while (!pix_valid && n < 100) begin @(negedge clock); n++; end
    check("hold_valid_seen", 32'(pix_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_pix_valid", 32'(pix_valid), 1);
      check("hold_pix_x", 32'(pix_x), 7);
      check("hold_pix_y", 32'(pix_y), 7);
      check("hold_pix_color", 32'(pix_color), 9);
      check("hold_no_rp_reset", 32'(rp_reset), 0);
      check("hold_no_rp_data_in", 32'(rp_data_in), 0);
    end
    @(posedge clock); #1 pix_ready = 1'b1;
    wait_done("hold_test", 200);

    // Silent rasterizer: background after the timeout.
    rast_mode = 1;
    expect_pix(3, 3, BG);
    go(3, 3, 3, 3, 1);
    wait_sig_datain("timeout_stream");
    @(posedge clock);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (pix_valid) begin n = i; break; end
    end
    check("timeout_latency", 32'(n), 15);
    wait_done("timeout_test", 200);
    rast_mode = 0;

    // No triangles: background without touching the rasterizer.
    din_cycles = 0;
    expect_pix(4, 4, BG);
    go(4, 4, 4, 4, 0);
    wait_done("zero_tris", 100);
    check("zero_tris_data_in", 32'(din_cycles), 0);

    // Empty region: straight to done, no pixels.
    snap = pix_seen; din_cycles = 0;
    go(5, 4, 0, 0, 1);
    wait_done("empty_region", 50);
    check("empty_region_pixels", 32'(pix_seen - snap), 0);
    check("empty_region_data_in", 32'(din_cycles), 0);

    // Top of the coordinate range ends by compare, not by wrap.
    expect_pix(262142, 262143, BG);
    expect_pix(262143, 262143, BG);
    go(262142, 262143, 262143, 262143, 0);
    wait_done("max_coord", 50);

    // Clamp to 64 entries; a write issued with start must not reach this scan.
    for (int i = 0; i < 64; i++) wr(i, make_tri(0, 0, 100, 0, 0, 100, 200 - i, 100 + i));
    din_cycles = 0;
    expect_pix(5, 5, 16'd163);
    tri_wr_en = 1'b1; tri_wr_addr = 6'd63;
    tri_wr_data = make_tri(0, 0, 100, 0, 0, 100, 1, 16'h7777);
    go(5, 5, 5, 5, 100);
    tri_wr_en = 1'b0;
    wait_done("clamp", 500);
    check("clamp_data_in", 32'(din_cycles), 64);

    // Reset during STREAM abandons the scan.
    go(30, 31, 30, 30, 4);
    wait_sig_datain("reset_stream");
    snap = done_seen;
    reset = 1'b0;
    #1;
    check("mid_rst_rp_data_in", 32'(rp_data_in), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rp_reset", 32'(rp_reset), 1);
    check("mid_rst_pix_valid", 32'(pix_valid), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_done", 32'(done_seen - snap), 0);
    check("mid_rst_idle", 32'(busy), 0);
    wr(0, make_tri(0, 0, 100, 0, 0, 100, 5, 42));
    expect_pix(1, 1, 16'd42);
    go(1, 1, 1, 1, 1);
    wait_done("after_reset", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
